// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag index and state definitions shared by the multi-cycle ALU
package alu_pkg;

    // primary opcodes
    localparam logic [3:0] OP_REG     = 4'b0000;
    localparam logic [3:0] OP_ANDI    = 4'b0001;
    localparam logic [3:0] OP_ORI     = 4'b0010;
    localparam logic [3:0] OP_XORI    = 4'b0011;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_ADDI    = 4'b0101;
    localparam logic [3:0] OP_MODI    = 4'b0110;
    localparam logic [3:0] OP_SHIFT   = 4'b1000;
    localparam logic [3:0] OP_SUBI    = 4'b1001;
    localparam logic [3:0] OP_CMPI    = 4'b1011;
    localparam logic [3:0] OP_MOVI    = 4'b1101;
    localparam logic [3:0] OP_LUI     = 4'b1111;

    // register class extensions
    localparam logic [3:0] EXT_AND    = 4'b0001;
    localparam logic [3:0] EXT_OR     = 4'b0010;
    localparam logic [3:0] EXT_XOR    = 4'b0011;
    localparam logic [3:0] EXT_ADD    = 4'b0101;
    localparam logic [3:0] EXT_SUB    = 4'b1001;
    localparam logic [3:0] EXT_CMP    = 4'b1011;
    localparam logic [3:0] EXT_MOV    = 4'b1101;
    localparam logic [3:0] EXT_MUL    = 4'b1110;

    // special class extensions
    localparam logic [3:0] EXT_LOAD   = 4'b0000;
    localparam logic [3:0] EXT_STORE  = 4'b0100;
    localparam logic [3:0] EXT_JCOND  = 4'b1100;
    localparam logic [3:0] EXT_JAL    = 4'b1000;

    // shift class extensions
    localparam logic [3:0] EXT_LSHI   = 4'b0000;
    localparam logic [3:0] EXT_RSHI   = 4'b0001;
    localparam logic [3:0] EXT_LSH    = 4'b0100;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - iterative shift-add multiplier / restoring remainder unit
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             fin
);
    localparam int CW = $clog2(WIDTH) + 1;

    // acc: product / partial remainder; opr: multiplicand / divisor; sr: multiplier / dividend
    logic             busy;
    logic             div;
    logic [WIDTH-1:0] acc, opr, sr;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] acc_n, opr_n, sr_n;
    logic [WIDTH:0]   r_sh, trial;

    always_comb begin
        r_sh  = {acc, sr[WIDTH-1]};
        trial = r_sh - {1'b0, opr};
        if (div) begin
            acc_n = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            sr_n  = {sr[WIDTH-2:0], ~trial[WIDTH]};
            opr_n = opr;
        end else begin
            acc_n = sr[0] ? acc + opr : acc;
            sr_n  = sr >> 1;
            opr_n = opr << 1;
        end
    end

    // the final step's value is offered combinationally so the top registers it on the same edge
    assign fin = busy && (cnt == CW'(WIDTH - 1));
    assign res = acc_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            div  <= 1'b0;
            acc  <= '0;
            opr  <= '0;
            sr   <= '0;
            cnt  <= '0;
        end else if (go) begin
            busy <= 1'b1;
            div  <= is_div;
            acc  <= '0;
            opr  <= is_div ? b : a;
            sr   <= is_div ? a : b;
            cnt  <= '0;
        end else if (busy) begin
            acc  <= acc_n;
            opr  <= opr_n;
            sr   <= sr_n;
            cnt  <= cnt + 1'b1;
            if (fin)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with start/ready/done handshake and registered result/psr
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op_code,
    input  logic [3:0]       op_ext,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       psr
);
    state_t           state, state_n;
    logic             load, go, is_iter, is_div, fin;
    logic [WIDTH-1:0] res_n, md_res, sc_res;
    logic [7:0]       psr_n, sc_psr;

    logic [WIDTH-1:0] b_sext, bx, diff, b_neg, lsh_res;
    logic [WIDTH:0]   sum;
    logic             add_ovf, sub_ovf, do_add, do_sub, do_cmp;

    assign is_div  = (op_code == OP_MODI);
    assign is_iter = is_div || (op_code == OP_REG && op_ext == EXT_MUL);

    // only the arithmetic immediates sign-extend; logic immediates arrive zero-extended in b
    assign b_sext  = {{(WIDTH-IMM_W){b[IMM_W-1]}}, b[IMM_W-1:0]};
    assign bx      = (op_code inside {OP_ADDI, OP_SUBI, OP_CMPI}) ? b_sext : b;
    assign sum     = {1'b0, a} + {1'b0, bx};
    assign diff    = a - bx;
    assign add_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != bx[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign b_neg   = -b;
    assign lsh_res = b[WIDTH-1] ? (a >> b_neg) : (a << b);

    always_comb begin
        sc_res = '0;
        sc_psr = psr;
        do_add = 1'b0;
        do_sub = 1'b0;
        do_cmp = 1'b0;
        case (op_code)
            OP_REG: begin
                case (op_ext)
                    EXT_AND: sc_res = a & b;
                    EXT_OR:  sc_res = a | b;
                    EXT_XOR: sc_res = a ^ b;
                    EXT_MOV: sc_res = b;
                    EXT_ADD: do_add = 1'b1;
                    EXT_SUB: do_sub = 1'b1;
                    EXT_CMP: do_cmp = 1'b1;
                    default: sc_res = '0;
                endcase
            end
            OP_ANDI: sc_res = a & b;
            OP_ORI:  sc_res = a | b;
            OP_XORI: sc_res = a ^ b;
            OP_MOVI: sc_res = b;
            OP_ADDI: do_add = 1'b1;
            OP_SUBI: do_sub = 1'b1;
            OP_CMPI: do_cmp = 1'b1;
            OP_LUI:  sc_res = WIDTH'(b[7:0]) << 8;
            OP_SPECIAL: begin
                if (op_ext inside {EXT_LOAD, EXT_STORE, EXT_JCOND, EXT_JAL})
                    sc_res = a + b;
            end
            OP_SHIFT: begin
                case (op_ext)
                    EXT_LSHI: sc_res = a << b;
                    EXT_RSHI: sc_res = a >> b;
                    EXT_LSH:  sc_res = lsh_res;
                    default:  sc_res = '0;
                endcase
            end
            default: sc_res = '0;
        endcase

        if (do_add) begin
            sc_res        = sum[WIDTH-1:0];
            sc_psr[PSR_C] = sum[WIDTH];
            sc_psr[PSR_F] = add_ovf;
        end
        if (do_sub) begin
            sc_res        = diff;
            sc_psr[PSR_C] = (a < bx);
            sc_psr[PSR_F] = sub_ovf;
        end
        if (do_cmp) begin
            sc_res        = result;
            sc_psr[PSR_L] = (a < bx);
            sc_psr[PSR_N] = ($signed(a) < $signed(bx));
            sc_psr[PSR_Z] = (a == bx);
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        go      = 1'b0;
        res_n   = result;
        psr_n   = psr;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter) begin
                        go      = 1'b1;
                        state_n = ST_ITER;
                    end else begin
                        load    = 1'b1;
                        res_n   = sc_res;
                        psr_n   = sc_psr;
                        state_n = ST_DONE;
                    end
                end
            end
            ST_ITER: begin
                if (fin) begin
                    load    = 1'b1;
                    res_n   = md_res;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            result <= '0;
            psr    <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                result <= res_n;
                psr    <= psr_n;
            end
        end
    end

    assign ready = (state == ST_IDLE);
    assign done  = (state == ST_DONE);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .is_div (is_div),
        .a      (a),
        .b      (b),
        .res    (md_res),
        .fin    (fin)
    );

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op_code = '0;
    logic [3:0]   op_ext = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, done;
    logic [W-1:0] result;
    logic [7:0]   psr;

    alu_mc #(.WIDTH(W), .IMM_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_code (op_code),
        .op_ext  (op_ext),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .result  (result),
        .psr     (psr)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           exp_done_cyc = -1;
    int           t_issue = 0;
    logic [15:0]  exp_res = '0, m_result = '0;
    logic [7:0]   exp_psr = '0, m_psr = '0;
    logic [3:0]   reg_tab [8] = '{EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_SUB, EXT_CMP, EXT_MOV, 4'b0000};
    logic [3:0]   sh_tab  [4] = '{EXT_LSHI, EXT_RSHI, EXT_LSH, 4'b0111};
    logic [3:0]   sp_tab  [4] = '{EXT_LOAD, EXT_STORE, EXT_JCOND, EXT_JAL};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sgn16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // expected outcome of one operation from the ISA rules, in plain integer arithmetic
    function automatic void model(input logic [3:0] opc, input logic [3:0] ext,
                                  input logic [15:0] av, input logic [15:0] bv,
                                  input logic [15:0] pr, input logic [7:0] pp,
                                  output logic [15:0] r, output logic [7:0] p, output bit it);
        int ai, bi, bx, sa, sb, sbx, kind;
        bit c, l, f, z, n;
        c = pp[4]; l = pp[3]; f = pp[2]; z = pp[1]; n = pp[0];
        ai = int'(av); bi = int'(bv);
        sa = sgn16(ai); sb = sgn16(bi);
        sbx = (opc == OP_ADDI || opc == OP_SUBI || opc == OP_CMPI) ?
              (bv[7] ? int'(bv[7:0]) - 256 : int'(bv[7:0])) : sb;
        bx = (sbx < 0) ? sbx + 65536 : sbx;
        r = '0; it = 0; kind = 0;
        case (opc)
            OP_REG: case (ext)
                EXT_AND: r = av & bv;
                EXT_OR:  r = av | bv;
                EXT_XOR: r = av ^ bv;
                EXT_MOV: r = bv;
                EXT_ADD: kind = 1;
                EXT_SUB: kind = 2;
                EXT_CMP: kind = 3;
                EXT_MUL: begin r = 16'((longint'(ai) * longint'(bi)) % 65536); it = 1; end
                default: r = '0;
            endcase
            OP_ANDI: r = av & bv;
            OP_ORI:  r = av | bv;
            OP_XORI: r = av ^ bv;
            OP_MOVI: r = bv;
            OP_ADDI: kind = 1;
            OP_SUBI: kind = 2;
            OP_CMPI: kind = 3;
            OP_MODI: begin r = (bi == 0) ? av : 16'(ai % bi); it = 1; end
            OP_LUI:  r = {bv[7:0], 8'h00};
            OP_SPECIAL: if (ext == EXT_LOAD || ext == EXT_STORE || ext == EXT_JCOND || ext == EXT_JAL)
                            r = 16'(ai + bi);
            OP_SHIFT: case (ext)
                EXT_LSHI: r = (bi >= 16) ? 16'h0 : 16'(ai << bi);
                EXT_RSHI: r = (bi >= 16) ? 16'h0 : 16'(ai >> bi);
                EXT_LSH:  r = (sb >= 0) ? ((sb >= 16) ? 16'h0 : 16'(ai << sb))
                                        : ((-sb >= 16) ? 16'h0 : 16'(ai >> (-sb)));
                default:  r = '0;
            endcase
            default: r = '0;
        endcase
        if (kind == 1) begin
            r = 16'(ai + bx); c = (ai + bx) > 65535;
            f = (sa + sbx) > 32767 || (sa + sbx) < -32768;
        end else if (kind == 2) begin
            r = 16'(ai - bx); c = ai < bx;
            f = (sa - sbx) > 32767 || (sa - sbx) < -32768;
        end else if (kind == 3) begin
            r = pr; l = ai < bx; n = sa < sbx; z = ai == bx;
        end
        p = {3'b000, c, l, f, z, n};
    endfunction

    // every-cycle compare against the model's view of the handshake and registers
    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset) begin
            m_result = '0;
            m_psr    = '0;
        end else if (cyc == exp_done_cyc) begin
            m_result = exp_res;
            m_psr    = exp_psr;
        end
        chk("ready", 32'(ready), 32'(reset || cyc > exp_done_cyc));
        chk("done", 32'(done), 32'(!reset && cyc == exp_done_cyc));
        chk("result", 32'(result), 32'(m_result));
        chk("psr", 32'(psr), 32'(m_psr));
    end

    task automatic issue(input logic [3:0] opc, input logic [3:0] ext,
                         input logic [15:0] av, input logic [15:0] bv);
        logic [15:0] r;
        logic [7:0]  p;
        bit          it;
        while (cyc <= exp_done_cyc) @(negedge clk);
        op_code = opc; op_ext = ext; a = av; b = bv; start = 1'b1;
        model(opc, ext, av, bv, m_result, m_psr, r, p, it);
        exp_res = r; exp_psr = p;
        exp_done_cyc = cyc + 1 + (it ? W : 0);
        t_issue = cyc;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        op_code = 4'($urandom); op_ext = 4'($urandom);
    endtask

    task automatic wait_done(input logic [15:0] lr, input logic [7:0] lp, input int lat, input string nm);
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            chk({nm, " timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, " res"}, 32'(result), 32'(lr));
            chk({nm, " psr"}, 32'(psr), 32'(lp));
            chk({nm, " latency"}, 32'(cyc - t_issue), 32'(lat));
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 8)
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            5: return 16'($urandom % 20);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] opc, ext;
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset psr", 32'(psr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(OP_REG, EXT_ADD, 16'hFFFF, 16'h0001);  wait_done(16'h0000, 8'h10, 1, "add carry");
        issue(OP_REG, EXT_ADD, 16'h7FFF, 16'h0001);  wait_done(16'h8000, 8'h04, 1, "add ovf");
        issue(OP_MOVI, 4'h0, 16'h0000, 16'h1234);    wait_done(16'h1234, 8'h04, 1, "movi");
        issue(OP_REG, EXT_CMP, 16'h0003, 16'h0005);  wait_done(16'h1234, 8'h0D, 1, "cmp lt");
        issue(OP_CMPI, 4'h0, 16'hFFFF, 16'h00FF);    wait_done(16'h1234, 8'h06, 1, "cmpi eq");

        issue(OP_REG, EXT_MUL, 16'd300, 16'd300);
        repeat (3) @(negedge clk);
        chk("mul busy ready", 32'(ready), 32'd0);
        start = 1'b1; op_code = OP_REG; op_ext = EXT_ADD; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        wait_done(16'h5F90, 8'h06, 17, "mul");

        issue(OP_MODI, 4'h0, 16'd100, 16'd7);        wait_done(16'h0002, 8'h06, 17, "modi");
        issue(OP_MODI, 4'h0, 16'h1234, 16'h0000);    wait_done(16'h1234, 8'h06, 17, "modi zero");
        issue(OP_SHIFT, EXT_LSH, 16'h8001, 16'hFFFF); wait_done(16'h4000, 8'h06, 1, "lsh neg");
        issue(OP_SHIFT, EXT_LSHI, 16'h0001, 16'd16);  wait_done(16'h0000, 8'h06, 1, "lshi wide");
        issue(OP_LUI, 4'h0, 16'h0000, 16'h00AB);      wait_done(16'hAB00, 8'h06, 1, "lui");

        issue(OP_REG, EXT_MUL, 16'd1234, 16'd5678);
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        exp_done_cyc = -1;
        #1;
        chk("async rst ready", 32'(ready), 32'd1);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst result", 32'(result), 32'd0);
        chk("async rst psr", 32'(psr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(OP_REG, EXT_ADD, 16'd2, 16'd3);         wait_done(16'h0005, 8'h00, 1, "add after rst");

        for (int i = 0; i < 120; i++) begin
            case ($urandom % 8)
                0: begin opc = OP_REG; ext = EXT_MUL; end
                1: begin opc = OP_MODI; ext = 4'($urandom); end
                2, 3: begin opc = OP_REG; ext = reg_tab[$urandom % 8]; end
                default: begin
                    opc = 4'($urandom); ext = 4'($urandom);
                    if (opc == OP_SHIFT) ext = sh_tab[$urandom % 4];
                    if (opc == OP_SPECIAL && ($urandom % 4) != 0) ext = sp_tab[$urandom % 4];
                end
            endcase
            issue(opc, ext, pick(), pick());
            if (($urandom % 3) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        while (cyc <= exp_done_cyc + 1) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the processor's combinational ALU. It registers `result` and the program status flags, and adds a start/ready/done handshake. Single-cycle ops complete in one clock; multiply and modulo run on an iterative datapath for `WIDTH` clocks. It sits between the controller FSM and the register file/PSR.

## Interface
- `WIDTH`, 16: datapath width. Legal values are ≥16.
- `IMM_W`, 8: immediate field width, sign-extended for addi/subi/cmpi.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: launch op; sampled only while `ready`=1.
- `op_code` in 4: primary opcode, same encoding as the existing ISA.
- `op_ext` in 4: extension field for register, special and shift classes.
- `a` in WIDTH: operand 1 (Rdest).
- `b` in WIDTH: operand 2 (Rsrc or zero-extended immediate).
- `ready` out 1: high in IDLE.
- `done` out 1: one-cycle pulse when `result`/`psr` are valid.
- `result` out WIDTH: registered result, held until the next `done`.
- `psr` out 8: registered flags `000CLFZN`. C=4, L=3, F=2, Z=1, N=0.

## Operation
- Reset values: `result`=0, `psr`=0, `done`=0, `ready`=1, state=IDLE, iteration counter=0.
- States and transitions:
  - IDLE:
    - `start` with MUL (0000/1110) or MODI (0110) → latch operands, go to ITER.
    - Any other op with `start` → compute, register, go to DONE.
  - ITER: runs `WIDTH` cycles, then goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Operands are latched at `start`. Input changes after `start` have no effect.
- Add/addi:
  - `result` = (a+b') mod 2^WIDTH, where b' is `b`, or `b[IMM_W-1:0]` sign-extended.
  - C = carry out of bit WIDTH-1.
  - F = signed overflow.
- Sub/subi:
  - C = unsigned a<b'.
  - F = signed overflow of a−b'.
- Cmp/cmpi:
  - `result` unchanged.
  - L = unsigned a<b'.
  - N = signed a<b'.
  - Z = (a==b').
- Flags not listed for an op are preserved. Logic, mov, movi, shift, lui, load/store/jcond/jal and mul/mod leave `psr` untouched.
- Logic ops (and/or/xor and immediate forms) are bitwise. mov/movi pass `b`.
- Special class (load, store, jcond, jal): `result`=a+b, no flags.
- Shifts, all logical:
  - LSHI = a<<b; RSHI = a>>b.
  - LSH: b is signed. b≥0 gives a<<b; b<0 gives a>>(−b).
  - Any shift magnitude ≥ WIDTH gives 0.
- LUI: `result` = b[7:0]<<8, zero elsewhere.
- MUL: shift-add, one partial product per cycle. Result is the low WIDTH bits.
- MODI: restoring division, one quotient bit per cycle. Result is the remainder.
  - b=0 needs no special case: the algorithm yields remainder = a.
- Unsupported opcode/ext: `result`=0, flags preserved, `done` still pulses.

## Timing
- Single-cycle ops: `start` at edge N, then `result`/`psr` update and `done`=1 in cycle N+1.
- MUL/MODI: `ready`=0 from N+1 through N+WIDTH+1. `done` pulses at N+WIDTH+1. `result` updates on the same edge as `done`.
- `ready` returns to 1 the cycle after `done`. Back-to-back single-cycle ops are therefore accepted every 2 cycles.
- `start` while `ready`=0 is ignored; it is not queued.
- `reset` mid-ITER or mid-DONE: immediate return to reset values. The partial result is discarded and no `done` is issued.

## Structure
- Package `alu_pkg` holds:
  - opcode/op_ext localparams (ADD, SUB, CMP, MUL, AND, OR, XOR, MOV, LOAD, STORE, JCOND, JAL, ADDI, MODI, SUBI, CMPI, MOVI, SHIFT, LSH, LSHI, RSHI, LUI);
  - PSR bit-index constants;
  - state encoding (IDLE, ITER, DONE).
- Sub-module `alu_iter_muldiv`:
  - Parametrised by `WIDTH`; contains the shared accumulator/shift register and the log2(WIDTH)+1-bit counter.
  - Inputs: `go`, `is_div`, `a`, `b`. Outputs: `res`, `fin`.
- The top level keeps the handshake FSM, single-cycle datapath and PSR register.

## Test plan
- add 0xFFFF+0x0001 → `result`=0x0000, C=1, F=0, `done` exactly 1 cycle after `start`. Then add 0x7FFF+0x0001 → 0x8000, F=1, C=0.
- cmp a=0x0003, b=0x0005 after a prior `result`=0x1234 → `result` stays 0x1234, L=1, N=1, Z=0. Then cmpi a=0xFFFF, imm 0xFF → Z=1.
- mul 300×300 → `result`=0x5F90, `done` 17 cycles after `start`, `ready`=0 during ITER. A `start` pulse at cycle 5 is ignored; `psr` is unchanged.
- modi 100%7 → 0x0002; modi 0x1234%0 → 0x1234. Both take 17 cycles.
- LSH a=0x8001, b=0xFFFF → 0x4000; LSHI a=0x0001, b=16 → 0x0000; lui b=0x00AB → 0xAB00.
- Assert `reset` at cycle 8 of a mul → `ready`=1, `result`=0, `psr`=0 without waiting for a clock, no `done`. A following add 2+3 → 0x0005 with normal latency.
